uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
UART transmit framer and serializer, the transmit-side counterpart of the receiver's parity checking path. Accepts one parallel byte per handshake and emits a serial frame on TX_OUT, one bit per CLK cycle. Frame order: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit. CLK is the TX baud-rate clock supplied by the system clock divider.

Parameters:
DATA_WIDTH, 8, payload bits per frame (legal range 5..9).

Ports:
CLK  input  1  TX baud clock; all logic on rising edge.
RST  input  1  synchronous reset, active-low.
P_DATA  input  DATA_WIDTH  parallel payload; sampled only on acceptance.
Data_Valid  input  1  payload request; accepted only in IDLE.
PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
TX_OUT  output  1  serial line, registered, idle high.
busy  output  1  registered; high for every cycle a frame bit is on TX_OUT.

Behaviour:
- Reset (RST low at a rising edge): state IDLE, TX_OUT=1, busy=0, shift register and bit counter cleared. Reset mid-frame abandons the frame; the line returns high at the next edge. No partial-frame completion.
- FSM states: IDLE, START, DATA, PARITY, STOP. Encoding lives in the package.
- IDLE: TX_OUT=1, busy=0. If Data_Valid=1 at edge k:
  - latch P_DATA, PAR_EN, PAR_TYP;
  - compute parity bit = ^P_DATA XOR PAR_TYP;
  - go to START.
- START: after edge k, TX_OUT=0, busy=1. Latency from accepting edge to start bit is exactly one edge. Advance to DATA.
- DATA: DATA_WIDTH cycles, TX_OUT = shift_reg[0], shifting right each cycle. The bit counter runs 0..DATA_WIDTH-1. At the last bit, go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY: one cycle, TX_OUT = latched parity bit. Even parity: total ones in data+parity is even. Odd parity: total ones is odd.
- STOP: one cycle, TX_OUT=1, busy=1, then go to IDLE.
- Data_Valid is ignored in every non-IDLE state. Requests are not queued. Upstream holds Data_Valid until it sees busy high, then drops it.
- Frame changes mid-frame: changes on P_DATA, PAR_EN or PAR_TYP after acceptance have no effect on the current frame.
- Frame length: 10 cycles without parity, 11 with parity (DATA_WIDTH=8). Minimum accept-to-accept spacing is frame length + 1, because one IDLE cycle is mandatory between frames.
- Data_Valid held continuously high: a new frame starts every frame+1 cycles with TX_OUT=1 for exactly one cycle between frames.
- TX_OUT and busy come directly from flops, so there are no glitches.

Optional Feature:
Macro UART_TX_TWO_STOP_EN.
- Defined: the STOP state lasts two cycles (TX_OUT=1, busy=1 both cycles). Frame length becomes 11/12 cycles.
- Undefined: single stop bit exactly as described above.
- Port list and parameters are identical in both builds.

Decomposition:
- Package uart_tx_pkg: FSM state typedef and encoding, STOP_BITS constant (1, or 2 under the macro), PAR_EVEN=0 and PAR_ODD=1 constants, and a frame-length function of DATA_WIDTH and PAR_EN.
- Sub-module uart_tx_serializer: load, shift and done-flag logic for the shift register and bit counter, driven by load/shift enables from the FSM.
- Parity is a single XOR-reduce and stays in the top level.

Test Plan:
- Reset: RST low for 2 cycles mid-frame (during DATA bit 3) -> TX_OUT=1, busy=0 at next edge; the following Data_Valid starts a clean frame.
- No parity: P_DATA=0xA5, PAR_EN=0, Data_Valid pulse at edge k -> TX_OUT from k+1 is 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop); busy high exactly 10 cycles.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, frame 11 cycles. With P_DATA=0x07 -> parity bit 1.
- Odd parity: P_DATA=0xA5, PAR_TYP=1 -> parity bit 1. With P_DATA=0x00 -> parity bit 1; with 0xFF -> parity bit 1.
- Busy protocol: Data_Valid held high, P_DATA changed to 0x3C mid-frame -> the current frame still sends 0xA5; the next frame sends 0x3C after exactly one idle-high cycle.
- Two stop bits (UART_TX_TWO_STOP_EN defined): 0xA5 with no parity -> two trailing 1s, busy high 11 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit framer.
// UART_TX_TWO_STOP_EN selects two stop bits instead of one.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Cycles busy is high for one frame.
    function automatic int frame_len(
        input int   dw,
        input logic par_en
    );
        return 1 + dw + (par_en ? 1 : 0) + STOP_BITS;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// Ports: CLK, RST (sync, active-low), load/shift enables, din,
// cur_bit/nxt_bit (shift_reg[0]/[1]), done (last data bit on wire).
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  cur_bit,
    output logic                  nxt_bit,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= din;
            bit_cnt   <= '0;
        end else if (shift) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
        end
    end

    assign cur_bit = shift_reg[0];
    assign nxt_bit = shift_reg[1];
    assign done    = (bit_cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, data LSB first, optional parity, stop.
// Ports: CLK, RST (sync, active-low), P_DATA, Data_Valid, PAR_EN,
// PAR_TYP -> TX_OUT (idle high), busy. Macro: UART_TX_TWO_STOP_EN.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_t state, next_state;

    logic       par_en_q;
    logic       par_bit_q;
    logic [0:0] stop_cnt;
    logic       stop_last;

    logic load, shift, stop_clr, stop_inc;
    logic tx_d, busy_d;
    logic cur_bit, nxt_bit, done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .CLK     (CLK),
        .RST     (RST),
        .load    (load),
        .shift   (shift),
        .din     (P_DATA),
        .cur_bit (cur_bit),
        .nxt_bit (nxt_bit),
        .done    (done)
    );

    assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

    // Outputs are registered from the next-cycle values, so the
    // START state is entered with TX_OUT already low.
    always_comb begin
        next_state = state;
        tx_d       = 1'b1;
        busy_d     = 1'b1;
        load       = 1'b0;
        shift      = 1'b0;
        stop_clr   = 1'b0;
        stop_inc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (Data_Valid) begin
                    next_state = ST_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    load       = 1'b1;
                end
            end
            ST_START: begin
                next_state = ST_DATA;
                tx_d       = cur_bit;
            end
            ST_DATA: begin
                if (done) begin
                    stop_clr = 1'b1;
                    if (par_en_q) begin
                        next_state = ST_PARITY;
                        tx_d       = par_bit_q;
                    end else begin
                        next_state = ST_STOP;
                    end
                end else begin
                    // cur_bit is on the wire; queue the next one.
                    tx_d  = nxt_bit;
                    shift = 1'b1;
                end
            end
            ST_PARITY: begin
                next_state = ST_STOP;
                stop_clr   = 1'b1;
            end
            ST_STOP: begin
                if (stop_last) begin
                    next_state = ST_IDLE;
                    busy_d     = 1'b0;
                end else begin
                    stop_inc = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ST_IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop_cnt  <= '0;
        end else begin
            state  <= next_state;
            TX_OUT <= tx_d;
            busy   <= busy_d;
            if (load) begin
                par_en_q  <= PAR_EN;
                par_bit_q <= (^P_DATA) ^ PAR_TYP;
            end
            if (stop_clr) begin
                stop_cnt <= '0;
            end else if (stop_inc) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

endmodule
